booth_divider: RTL and testbench



---
 rtl/booth_div_pkg.sv | 16 +
 rtl/div_restore_step.sv | 24 ++
 rtl/booth_divider.sv | 130 +++++++++++++
 tb/tb_booth_divider.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_div_pkg.sv
// Shared types and default widths for the sequential signed divider.
// The divider sits beside the radix-4 Booth multiplier on the coprocessor bus.
package booth_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

    localparam int DEF_DIVIDEND_W = 32;
    localparam int DEF_DIVISOR_W  = 16;
    localparam int DEF_COUNT_W    = $clog2(DEF_DIVIDEND_W);

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
// It shifts the next dividend bit into the partial remainder and subtracts when possible.
module div_restore_step #(
    parameter int DIVISOR_W = 16
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    localparam int RW = DIVISOR_W + 1;

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] divisor_ext;

    // One extra bit of headroom so the compare never wraps.
    assign shifted     = {rem_in, bit_in};
    assign divisor_ext = {2'b00, divisor};
    assign q_bit       = (shifted >= divisor_ext);
    assign rem_out     = q_bit ? RW'(shifted - divisor_ext) : shifted[DIVISOR_W:0];

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: restoring division on magnitudes, then sign fix-up.
// It uses the same start-edge / busy / irq / ack handshake as the Booth multiplier.
module booth_divider
    import booth_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  ack,
    input  logic                  irq_enable,
    input  logic [DIVIDEND_W-1:0] data_a,
    input  logic [DIVISOR_W-1:0]  data_b,
    output logic                  busy,
    output logic                  irq,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] MOST_NEG = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    div_state_t             state;
    logic                   start_d;
    logic                   launch;
    logic [CNT_W-1:0]       count;
    logic [DIVIDEND_W-1:0]  dvd_shift;
    logic [DIVISOR_W-1:0]   dvs_mag;
    logic [DIVISOR_W:0]     part_rem;
    logic                   sign_a;
    logic                   sign_b;
    logic                   zero_pend;
    logic                   ovf_pend;
    logic [DIVIDEND_W-1:0]  a_mag;
    logic [DIVISOR_W-1:0]   b_mag;
    logic [DIVISOR_W-1:0]   rem_mag;
    logic [DIVISOR_W:0]     step_rem;
    logic                   step_q;

    assign launch  = start & ~start_d;
    assign a_mag   = data_a[DIVIDEND_W-1] ? -data_a : data_a;
    assign b_mag   = data_b[DIVISOR_W-1] ? -data_b : data_b;
    assign rem_mag = part_rem[DIVISOR_W-1:0];

    div_restore_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .rem_in (part_rem),
        .bit_in (dvd_shift[DIVIDEND_W-1]),
        .divisor(dvs_mag),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            start_d     <= 1'b0;
            count       <= '0;
            dvd_shift   <= '0;
            dvs_mag     <= '0;
            part_rem    <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            zero_pend   <= 1'b0;
            ovf_pend    <= 1'b0;
            busy        <= 1'b0;
            irq         <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            start_d <= start;
            case (state)
                IDLE: begin
                    if (launch) begin
                        dvd_shift   <= a_mag;
                        dvs_mag     <= b_mag;
                        part_rem    <= '0;
                        sign_a      <= data_a[DIVIDEND_W-1];
                        sign_b      <= data_b[DIVISOR_W-1];
                        zero_pend   <= (data_b == '0);
                        ovf_pend    <= (data_a == MOST_NEG) && (data_b == '1);
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        count       <= '0;
                        busy        <= 1'b1;
                        state       <= (data_b == '0) ? FIX : RUN;
                    end
                end
                // The dividend register doubles as the quotient shift register.
                RUN: begin
                    part_rem  <= step_rem;
                    dvd_shift <= {dvd_shift[DIVIDEND_W-2:0], step_q};
                    count     <= count + CNT_W'(1);
                    if (count == CNT_W'(DIVIDEND_W - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zero_pend) begin
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= (sign_a ^ sign_b) ? -dvd_shift : dvd_shift;
                        remainder <= sign_a ? -rem_mag : rem_mag;
                        overflow  <= ovf_pend;
                    end
                    irq   <= irq_enable;
                    state <= DONE;
                end
                DONE: begin
                    if (ack) begin
                        busy  <= 1'b0;
                        irq   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider: expected results are queued at launch
// and compared once the divider reports completion.
module tb_booth_divider;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic        irq_enable = 1'b0;
    logic [31:0] data_a = '0;
    logic [15:0] data_b = '0;
    logic        busy;
    logic        irq;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        logic        irq;
    } exp_t;

    exp_t sb[$];

    booth_divider dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .ack        (ack),
        .irq_enable (irq_enable),
        .data_a     (data_a),
        .data_b     (data_b),
        .busy       (busy),
        .irq        (irq),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checkCount++;
        if (obs === expv) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    // Reference: 64-bit signed division truncates toward zero, and the low 32 bits wrap -2^31/-1.
    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input logic irqen);
        exp_t   e;
        longint la, lb, lq, lr;
        e.irq = irqen;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == 16'h0000) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = 16'h0000;
            e.dbz = 1'b1;
        end else begin
            la    = longint'(signed'(a));
            lb    = longint'(signed'(b));
            lq    = la / lb;
            lr    = la % lb;
            e.q   = lq[31:0];
            e.r   = lr[15:0];
            e.ovf = (a == 32'h8000_0000) && (b == 16'hFFFF);
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [15:0] b, input logic irqen,
                                 input bit hold, input bit score);
        @(negedge clk);
        data_a     = a;
        data_b     = b;
        irq_enable = irqen;
        start      = 1'b1;
        if (score) sb.push_back(model(a, b, irqen));
        @(negedge clk);
        if (!hold) start = 1'b0;
        data_a = ~a;
        data_b = ~b;
    endtask

    task automatic waitResult(input string tag, input bit midAck);
        exp_t e;
        int   lat;
        checkOutput({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e   = sb.pop_front();
        lat = e.dbz ? 2 : 33;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            ack = midAck && (i == 5);
        end
        ack = 1'b0;
        if (!e.dbz) begin
            checkOutput({tag, "_busy_pre"}, 64'(busy), 64'd1);
            checkOutput({tag, "_irq_pre"}, 64'(irq), 64'd0);
        end
        @(negedge clk);
        checkOutput({tag, "_quotient"}, 64'(quotient), 64'(e.q));
        checkOutput({tag, "_remainder"}, 64'(remainder), 64'(e.r));
        checkOutput({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
        checkOutput({tag, "_overflow"}, 64'(overflow), 64'(e.ovf));
        checkOutput({tag, "_irq"}, 64'(irq), 64'(e.irq));
        checkOutput({tag, "_busy_done"}, 64'(busy), 64'd1);
    endtask

    task automatic doAck(input string tag);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checkOutput({tag, "_busy_ack"}, 64'(busy), 64'd0);
        checkOutput({tag, "_irq_ack"}, 64'(irq), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks passed %0d of %0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [15:0] rb;
        logic [31:0] heldQ;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_irq", 64'(irq), 64'd0);
        checkOutput("reset_quotient", 64'(quotient), 64'd0);
        checkOutput("reset_remainder", 64'(remainder), 64'd0);
        checkOutput("reset_flags", 64'({div_by_zero, overflow}), 64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(32'd100, 16'd7, 1'b1, 1'b0, 1'b1);
        waitResult("t1_100_7", 1'b0);
        doAck("t1");

        applyStimulus(-32'sd100, 16'd7, 1'b1, 1'b0, 1'b1);
        waitResult("t2_neg100_7", 1'b0);
        doAck("t2a");
        applyStimulus(-32'sd5535, -16'sd45, 1'b1, 1'b0, 1'b1);
        waitResult("t2_neg5535_neg45", 1'b0);
        doAck("t2b");

        applyStimulus(32'h8000_0000, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        waitResult("t3_overflow", 1'b0);
        doAck("t3");

        applyStimulus(32'd1234, 16'd0, 1'b1, 1'b0, 1'b1);
        waitResult("t4_zero", 1'b0);
        doAck("t4");

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = 16'($urandom_range(1, 65535));
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            waitResult($sformatf("rand%0d", i), 1'b0);
            doAck($sformatf("rand%0d", i));
        end

        // Start held high, ack pulsed mid-RUN, then ack coinciding with a fresh start edge.
        applyStimulus(32'd1000, -16'sd3, 1'b0, 1'b1, 1'b1);
        waitResult("t5_handshake", 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("t5_busy_held_done", 64'(busy), 64'd1);
        checkOutput("t5_irq_never", 64'(irq), 64'd0);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        ack   = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (3) @(negedge clk);
        heldQ = model(32'd1000, -16'sd3, 1'b0).q;
        checkOutput("t5_no_launch_busy", 64'(busy), 64'd0);
        checkOutput("t5_quotient_held", 64'(quotient), 64'(heldQ));
        start = 1'b0;
        @(negedge clk);

        applyStimulus(32'd77777, 16'd13, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checkOutput("t6_busy_rst", 64'(busy), 64'd0);
        checkOutput("t6_irq_rst", 64'(irq), 64'd0);
        checkOutput("t6_quotient_rst", 64'(quotient), 64'd0);
        checkOutput("t6_remainder_rst", 64'(remainder), 64'd0);
        checkOutput("t6_flags_rst", 64'({div_by_zero, overflow}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("t6_busy_after_release", 64'(busy), 64'd0);
        applyStimulus(32'd50, -16'sd5, 1'b1, 1'b0, 1'b1);
        waitResult("t6_50_neg5", 1'b0);
        doAck("t6");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
